// File: rtl/cv32e40p_obi_trans_limiter.sv
// OBI transaction limiter: caps in-flight transactions with a credit counter,
// tags requests and returns buffered, in-order responses with back-pressure.
module cv32e40p_obi_trans_limiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TAG_WIDTH       = 4,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; valid never depends on ready, and payload is stable while valid & !ready.
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          req_addr_i,
  input  logic                 req_we_i,
  input  logic [3:0]           req_be_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  output logic                 trans_valid_o,
  input  logic                 trans_ready_i,
  output logic [31:0]          trans_addr_o,
  output logic                 trans_we_o,
  output logic [3:0]           trans_be_o,
  output logic [31:0]          trans_wdata_o,
  output logic [5:0]           trans_atop_o,
  input  logic                 resp_valid_i,
  input  logic [31:0]          resp_rdata_i,
  input  logic                 resp_err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_we_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output logic [CW-1:0]        outstanding_o,
  output logic                 idle_o,
  output logic                 spurious_o
);

  localparam int unsigned TE = TAG_WIDTH + 1;
  localparam int unsigned RE = 34 + TAG_WIDTH;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_tag_cnt;
  logic [CW-1:0] r_rsp_cnt;
  logic [PW-1:0] r_tag_wr;
  logic [PW-1:0] r_tag_rd;
  logic [PW-1:0] r_rsp_wr;
  logic [PW-1:0] r_rsp_rd;
  logic [TE-1:0] r_tag_mem [MAX_OUTSTANDING];
  logic [RE-1:0] r_rsp_mem [MAX_OUTSTANDING];
  logic          r_spurious;

  logic          w_credit_ok;
  logic          w_accept;
  logic          w_tag_empty;
  logic          w_resp_push;
  logic          w_rsp_pop;
  logic [TE-1:0] w_tag_head;
  logic [RE-1:0] w_rsp_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready is gated only by the registered count, never by this cycle's pop,
  // so it does not combinationally depend on rsp_ready_i.
  assign w_credit_ok = (r_cnt < CW'(MAX_OUTSTANDING));
  assign w_accept    = req_valid_i & trans_ready_i & w_credit_ok;
  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_resp_push = resp_valid_i & !w_tag_empty;
  assign w_rsp_pop   = rsp_valid_o & rsp_ready_i;
  assign w_tag_head  = r_tag_mem[r_tag_rd];
  assign w_rsp_head  = r_rsp_mem[r_rsp_rd];

  assign trans_valid_o = req_valid_i & w_credit_ok;
  assign req_ready_o   = trans_ready_i & w_credit_ok;
  assign trans_addr_o  = req_addr_i;
  assign trans_we_o    = req_we_i;
  assign trans_be_o    = req_be_i;
  assign trans_wdata_o = req_wdata_i;
  assign trans_atop_o  = 6'd0;

  assign rsp_valid_o = (r_rsp_cnt != '0);
  assign {rsp_rdata_o, rsp_err_o, rsp_we_o, rsp_tag_o} = w_rsp_head;

  assign outstanding_o = r_cnt;
  assign idle_o        = (r_cnt == '0);
  assign spurious_o    = r_spurious;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_tag_cnt  <= '0;
      r_rsp_cnt  <= '0;
      r_tag_wr   <= '0;
      r_tag_rd   <= '0;
      r_rsp_wr   <= '0;
      r_rsp_rd   <= '0;
      r_spurious <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + CW'(w_accept) - CW'(w_rsp_pop);
      r_tag_cnt <= r_tag_cnt + CW'(w_accept) - CW'(w_resp_push);
      r_rsp_cnt <= r_rsp_cnt + CW'(w_resp_push) - CW'(w_rsp_pop);
      if (w_accept)    r_tag_wr <= ptr_inc(r_tag_wr);
      if (w_resp_push) r_tag_rd <= ptr_inc(r_tag_rd);
      if (w_resp_push) r_rsp_wr <= ptr_inc(r_rsp_wr);
      if (w_rsp_pop)   r_rsp_rd <= ptr_inc(r_rsp_rd);
      if (resp_valid_i && w_tag_empty) r_spurious <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and counts decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_accept)    r_tag_mem[r_tag_wr] <= {req_we_i, req_tag_i};
    if (!rst && w_resp_push) r_rsp_mem[r_rsp_wr] <= {resp_rdata_i, resp_err_i, w_tag_head};
  end

endmodule

// File: tb/tb_cv32e40p_obi_trans_limiter.sv
// Bench for cv32e40p_obi_trans_limiter: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_cv32e40p_obi_trans_limiter;

  localparam int unsigned MAX = 2;
  localparam int unsigned TW  = 4;
  localparam int unsigned CW  = $clog2(MAX + 1);

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic [TW-1:0] req_tag;
  logic          trans_valid;
  logic          trans_ready;
  logic [31:0]   trans_addr;
  logic          trans_we;
  logic [3:0]    trans_be;
  logic [31:0]   trans_wdata;
  logic [5:0]    trans_atop;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_we;
  logic [TW-1:0] rsp_tag;
  logic [CW-1:0] outstanding;
  logic          idle;
  logic          spurious;

  cv32e40p_obi_trans_limiter #(.MAX_OUTSTANDING(MAX), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_be_i(req_be),
    .req_wdata_i(req_wdata), .req_tag_i(req_tag),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready),
    .trans_addr_o(trans_addr), .trans_we_o(trans_we), .trans_be_o(trans_be),
    .trans_wdata_o(trans_wdata), .trans_atop_o(trans_atop),
    .resp_valid_i(resp_valid), .resp_rdata_i(resp_rdata), .resp_err_i(resp_err),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_we_o(rsp_we), .rsp_tag_o(rsp_tag),
    .outstanding_o(outstanding), .idle_o(idle), .spurious_o(spurious)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: transactions sent and awaiting a response, and
  // responses received and awaiting the requester.
  typedef struct packed { logic we; logic [TW-1:0] tag; } pend_t;
  typedef struct packed { logic [31:0] rdata; logic err; logic we; logic [TW-1:0] tag; } rsp_t;
  pend_t pend_q[$];
  rsp_t  exp_q[$];
  logic  m_spur;
  int    total;
  int    bad;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int credits;
    credits = pend_q.size() + exp_q.size();
    check("trans_valid", trans_valid, req_valid && (credits < MAX));
    check("req_ready", req_ready, trans_ready && (credits < MAX));
    check("trans_addr", trans_addr, req_addr);
    check("trans_we", trans_we, req_we);
    check("trans_be", trans_be, req_be);
    check("trans_wdata", trans_wdata, req_wdata);
    check("trans_atop", trans_atop, 0);
    check("outstanding", outstanding, credits);
    check("idle", idle, credits == 0);
    check("spurious", spurious, m_spur);
    check("rsp_valid", rsp_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
      check("rsp_err", rsp_err, exp_q[0].err);
      check("rsp_we", rsp_we, exp_q[0].we);
      check("rsp_tag", rsp_tag, exp_q[0].tag);
    end
  endtask

  // Driver: one clock cycle of stimulus, checked mid-cycle, then the model steps.
  task automatic cyc(input logic rv, input logic we, input logic [TW-1:0] tag,
                     input logic tr, input logic resv, input logic [31:0] rd,
                     input logic err, input logic rr, input logic rs, input logic chk);
    int    credits;
    logic  acc;
    logic  popb;
    pend_t p;
    rsp_t  r;
    rst         = rs;
    req_valid   = rv;
    req_we      = we;
    req_tag     = tag;
    req_addr    = $urandom;
    req_be      = 4'($urandom_range(0, 15));
    req_wdata   = $urandom;
    trans_ready = tr;
    resp_valid  = resv;
    resp_rdata  = rd;
    resp_err    = err;
    rsp_ready   = rr;
    #4;
    if (chk) check_outputs();
    if (rs) begin
      pend_q.delete();
      exp_q.delete();
      m_spur = 1'b0;
    end else begin
      credits = pend_q.size() + exp_q.size();
      acc  = rv && tr && (credits < MAX);
      popb = (exp_q.size() > 0) && rr;
      if (popb) void'(exp_q.pop_front());
      if (resv) begin
        if (pend_q.size() == 0) m_spur = 1'b1;
        else begin
          p = pend_q.pop_front();
          r.rdata = rd; r.err = err; r.we = p.we; r.tag = p.tag;
          exp_q.push_back(r);
        end
      end
      if (acc) begin
        p.we = we; p.tag = tag;
        pend_q.push_back(p);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_spur = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    check("reset_outstanding", outstanding, 0);
    check("reset_idle", idle, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_spurious", spurious, 0);

    // Single read: accept in N, response in N+2, visible in N+3
    cyc(1, 0, 4'd3, 1, 0, 0, 0, 0, 0, 1);
    check("single_outstanding", outstanding, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 1);
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rdata", rsp_rdata, 32'hDEADBEEF);
    check("single_tag", rsp_tag, 3);
    check("single_we", rsp_we, 0);
    check("single_err", rsp_err, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    check("single_drained", outstanding, 0);

    // Credit limit: third request blocked until a response is popped
    cyc(1, 0, 4'd1, 1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 4'd2, 1, 0, 0, 0, 0, 0, 1);
    check("limit_outstanding", outstanding, 2);
    cyc(1, 0, 4'd5, 1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 4'd5, 1, 1, 32'h11111111, 0, 0, 0, 1);
    cyc(1, 0, 4'd5, 1, 0, 0, 0, 1, 0, 1);
    cyc(1, 0, 4'd5, 1, 0, 0, 0, 0, 0, 1);
    check("limit_third_accepted", outstanding, 2);

    // Back-pressure: two responses held, then released in order
    cyc(0, 0, 0, 1, 1, 32'h22222222, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 32'h55555555, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    check("bp_head_tag", rsp_tag, 2);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    check("bp_second_tag", rsp_tag, 5);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    check("bp_drained", idle, 1);

    // Simultaneous accept and pop at cnt=1; write with error
    cyc(1, 1, 4'd6, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 32'h0, 1, 0, 0, 1);
    check("wr_err", rsp_err, 1);
    check("wr_we", rsp_we, 1);
    cyc(1, 0, 4'd7, 1, 0, 0, 0, 1, 0, 1);
    check("simul_outstanding", outstanding, 1);
    cyc(0, 0, 0, 1, 1, 32'hCAFEF00D, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic rv, tr, resv, rr;
      rv   = ($urandom_range(0, 3) != 0);
      tr   = ($urandom_range(0, 4) != 0);
      resv = (pend_q.size() > 0) && ($urandom_range(0, 2) != 0);
      rr   = ($urandom_range(0, 2) != 0);
      cyc(rv, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)), tr, resv,
          $urandom, 1'($urandom_range(0, 1)), rr, 0, 1);
    end

    // Drain, then spurious response
    for (int i = 0; i < 50 && (pend_q.size() + exp_q.size()) > 0; i++)
      cyc(0, 0, 0, 1, pend_q.size() > 0, $urandom, 0, 1, 0, 1);
    check("drain_idle", idle, 1);
    cyc(0, 0, 0, 1, 1, 32'h12345678, 0, 1, 0, 1);
    check("spurious_set", spurious, 1);
    check("spurious_no_rsp", rsp_valid, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    check("spurious_sticky", spurious, 1);

    // Reset mid-flight with cnt=2 and one buffered response
    cyc(1, 0, 4'd8, 1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 4'd9, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 32'hABCD0123, 0, 0, 0, 1);
    check("pre_reset_outstanding", outstanding, 2);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    check("midreset_rsp_valid", rsp_valid, 0);
    check("midreset_outstanding", outstanding, 0);
    check("midreset_idle", idle, 1);
    check("midreset_spurious", spurious, 0);
    cyc(0, 0, 0, 1, 1, 32'h9, 0, 1, 0, 1);
    check("post_reset_spurious", spurious, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
